serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored); sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port: cin  input  1  carry-in for add; sampled with start.
REQ-009 SHALL have port: busy  output  1  high while bits are being processed (RUN).
REQ-010 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port: sum  output  WIDTH  result register.
REQ-012 SHALL have port: cout  output  1  final carry-out; for sub, 1 = no borrow.
REQ-013 SHALL have port: ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 SHALL compute exactly one result bit per cycle through a single 1-bit full adder built from two half adders (sum = s1^c, carry = (a&b)|(s1&c)); no WIDTH-wide adder SHALL be used.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: start=1 at an edge -> latch a, sub ? ~b : b, carry register = sub ? 1 : cin, bit counter = 0; go to RUN.
REQ-017 IDLE with start=0 -> remain in IDLE; sum/cout/ovf hold their values.
REQ-018 RUN: each edge processes bit index = counter, LSB first; writes sum[index], updates carry register, increments counter.
REQ-019 RUN SHALL last exactly WIDTH cycles; the edge processing bit WIDTH-1 also captures cout = final carry, ovf = carry-in-to-MSB XOR final carry, and goes to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; never both.
REQ-022 Latency: done is high in the cycle following the WIDTH-th rising edge after the edge that sampled start; the next start is accepted no earlier than the edge ending DONE+1 (i.e. in IDLE).
REQ-023 start asserted in RUN or DONE SHALL be ignored (not queued); operand inputs changing during RUN SHALL not affect the result.
REQ-024 sum/cout/ovf SHALL hold the last completed result through IDLE until the next accepted start; sum bits update progressively during RUN.
REQ-025 Counter SHALL be $clog2(WIDTH) bits wide and never wrap past WIDTH-1 within an operation.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry register=0, counter=0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; after release the block waits in IDLE for a new start.
REQ-028 start high on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-029 WIDTH=8: start, sub=0, a=8'hFF, b=8'h01, cin=0 -> busy high 8 cycles, done pulse once, sum=8'h00, cout=1, ovf=0.
REQ-030 WIDTH=8: sub=0, a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1; sub=0, a=8'h12, b=8'h34, cin=1 -> sum=8'h47, cout=0, ovf=0.
REQ-031 WIDTH=8: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0 (borrow); sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
REQ-032 start pulsed again at RUN cycle 3 with different operands -> ignored; first result completes unchanged; exactly one done pulse.
REQ-033 rst asserted at RUN cycle 4 -> outputs 0 immediately, no done; new start afterwards with a=8'h0A, b=8'h05, sub=0, cin=0 -> sum=8'h0F.
REQ-034 Randomized back-to-back starts (start held high) for 1000 operations -> each result matches reference a±b, done spacing = WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller: one result bit per cycle,
// LSB first, through a single full adder built from two half adders.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic ai;
  logic bi;
  logic s1;
  logic c1;
  logic fs;
  logic fc;

  // b_r already holds ~b for subtract, so the adder never changes mode
  always_comb begin
    ai = a_r[cnt];
    bi = b_r[cnt];
    s1 = ai ^ bi;
    c1 = ai & bi;
    fs = s1 ^ carry;
    fc = c1 | (s1 & carry);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[cnt] <= fs;
          carry    <= fc;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB here
            cout  <= fc;
            ovf   <= carry ^ fc;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed vector table plus hand-written corner sequences and a
// back-to-back run against a behavioural reference.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] ref_op(input logic s_, input logic [7:0] x,
                                        input logic [7:0] y, input logic c);
    logic [8:0] t;
    logic [7:0] r;
    logic       co;
    logic       ov;
    if (s_) begin
      r  = x - y;
      co = (x >= y);
      ov = (x[7] != y[7]) && (r[7] != x[7]);
    end else begin
      t  = {1'b0, x} + {1'b0, y} + {8'd0, c};
      r  = t[7:0];
      co = t[8];
      ov = (x[7] == y[7]) && (r[7] != x[7]);
    end
    return {co, ov, r};
  endfunction

  // Called just after a negedge; start is driven immediately.
  // inj >= 0 pulses start with other operands at that RUN cycle.
  task automatic do_op(input string nm, input vec_t v, input int inj);
    int nb;
    int cyc;
    logic [7:0] s0;
    start = 1'b1;
    sub   = v.sub;
    a     = v.a;
    b     = v.b;
    cin   = v.cin;
    @(negedge clk);
    start = 1'b0;
    nb  = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      if (cyc == inj) begin
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h44;
        sub   = ~v.sub;
      end else begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({nm, ".done_seen"}, {31'd0, done}, 32'd1);
    chk({nm, ".busy_cycles"}, nb, 8);
    chk({nm, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({nm, ".sum"}, {24'd0, sum}, {24'd0, v.s});
    chk({nm, ".cout"}, {31'd0, cout}, {31'd0, v.co});
    chk({nm, ".ovf"}, {31'd0, ovf}, {31'd0, v.ov});
    s0 = sum;
    @(negedge clk);
    chk({nm, ".done_pulse"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk({nm, ".hold"}, {22'd0, cout, ovf, sum}, {22'd0, v.co, v.ov, s0});
  endtask

  initial begin
    int ndone;
    int w;
    int cyc;
    int last;
    logic [9:0] e;
    vec_t v;

    vt[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[2] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vt[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[7] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[8] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[9] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    chk("reset.outs", {21'd0, busy, done, cout, ovf, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vt[i], -1);

    // start re-pulsed at RUN cycle 3 must be ignored
    do_op("ignore", vt[2], 3);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ignore.no_extra_done", ndone, 0);

    // async reset mid-RUN
    v = vt[4];
    start = 1'b1;
    sub   = v.sub;
    a     = v.a;
    b     = v.b;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.outs", {21'd0, busy, done, cout, ovf, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("rst_mid.no_done", ndone, 0);

    // start on the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v = '{1'b0, 8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0, 1'b0};
    do_op("after_rst", v, -1);

    // back-to-back with start held high
    start = 1'b1;
    sub   = $urandom;
    a     = $urandom;
    b     = $urandom;
    cin   = $urandom;
    cyc   = 0;
    last  = 0;
    for (int n = 0; n < 1000; n++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
        cyc++;
      end while (!done && w < 40);
      if (!done) begin
        chk("b2b.timeout", 32'd0, 32'd1);
        break;
      end
      e = ref_op(sub, a, b, cin);
      chk("b2b.result", {22'd0, cout, ovf, sum}, {22'd0, e});
      if (n > 0) chk("b2b.spacing", cyc - last, 10);
      last = cyc;
      sub = $urandom;
      a   = $urandom;
      b   = $urandom;
      cin = $urandom;
    end
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
